// File: rtl/reg_file_pkg.sv
// Shared definitions for the two-read/one-write register file.
//   WIDTH_DEF / DEPTH_DEF / ADDR_DEF : default geometry
//   strb_merge()                     : byte-strobed merge of a stored word with write data
//   params_ok()                      : geometry sanity check used at elaboration
package reg_file_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 8;
  localparam int ADDR_DEF  = 3;

  // strb_merge works on a fixed wide word; callers zero-extend into it and
  // truncate the result back to their own WIDTH.
  localparam int MERGE_WIDTH = 256;
  localparam int MERGE_STRB  = MERGE_WIDTH / 8;

  function automatic logic [MERGE_WIDTH-1:0] strb_merge(
    input logic [MERGE_WIDTH-1:0] old_word,
    input logic [MERGE_WIDTH-1:0] new_word,
    input logic [MERGE_STRB-1:0]  strb
  );
    logic [MERGE_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_STRB; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

  function automatic bit params_ok(input int width, input int depth, input int addr);
    return (width > 0) && (width % 8 == 0) && (width <= MERGE_WIDTH) &&
           (depth >= 2) && (addr > 0) && (addr < 31) && (depth <= (1 << addr));
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port of the register file.
//   clk_sys, rst_b        : clock, synchronous active-low reset
//   rd_en, rd_addr        : read request
//   entries               : current storage contents, entry i at [i*WIDTH +: WIDTH]
//   wr_en/addr/data/strb  : the write issued in the same cycle (for bypass)
//   rd_data, rd_valid     : registered result and one-cycle fresh flag
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR     = ADDR_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic                   clk_sys,
  input  logic                   rst_b,
  input  logic                   rd_en,
  input  logic [ADDR-1:0]        rd_addr,
  input  logic [DEPTH*WIDTH-1:0] entries,
  input  logic                   wr_en,
  input  logic [ADDR-1:0]        wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [WIDTH/8-1:0]     wr_strb,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid
);

  localparam int ADDR_EXT = ADDR + 1;

  logic             in_range;
  logic             is_zero;
  logic             wr_hit;
  logic [WIDTH-1:0] stored;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] read_word;

  always_comb begin
    stored = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR'(i)) stored = entries[i*WIDTH +: WIDTH];
    end
  end

  // Extra bit keeps the compare meaningful when DEPTH == 2**ADDR.
  assign in_range = {1'b0, rd_addr} < ADDR_EXT'(DEPTH);
  assign is_zero  = (ZERO_REG != 0) && (rd_addr == '0);
  // Out-of-range or zero-entry writes never land; those reads return 0 below anyway.
  assign wr_hit   = wr_en && (wr_addr == rd_addr);
  assign merged   = WIDTH'(strb_merge(MERGE_WIDTH'(stored), MERGE_WIDTH'(wr_data),
                                      MERGE_STRB'(wr_strb)));

  always_comb begin
    read_word = '0;
    if (in_range && !is_zero) read_word = wr_hit ? merged : stored;
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= read_word;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with byte strobes and write-first bypass.
//   CLK, RST              : clock, synchronous active-low reset
//   WrEn/WrAddr/WrData/WrStrb : byte-strobed write port
//   RdEnA/RdAddrA, RdEnB/RdAddrB : read requests
//   RdDataA/RdValidA, RdDataB/RdValidB : registered read results
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR     = ADDR_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WrEn,
  input  logic [ADDR-1:0]    WrAddr,
  input  logic [WIDTH-1:0]   WrData,
  input  logic [WIDTH/8-1:0] WrStrb,
  input  logic               RdEnA,
  input  logic [ADDR-1:0]    RdAddrA,
  input  logic               RdEnB,
  input  logic [ADDR-1:0]    RdAddrB,
  output logic [WIDTH-1:0]   RdDataA,
  output logic               RdValidA,
  output logic [WIDTH-1:0]   RdDataB,
  output logic               RdValidB
);

  if (!params_ok(WIDTH, DEPTH, ADDR)) begin : g_param_check
    $error("reg_file_2r1w: WIDTH must be a multiple of 8 and DEPTH must fit in ADDR bits");
  end

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Out-of-range addresses match no entry, so those writes drop naturally.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      mem <= '0;
    end else if (WrEn) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((WrAddr == ADDR'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
          mem[i] <= WIDTH'(strb_merge(MERGE_WIDTH'(mem[i]), MERGE_WIDTH'(WrData),
                                      MERGE_STRB'(WrStrb)));
        end
      end
    end
  end

  reg_file_rd_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .ZERO_REG(ZERO_REG)
  ) u_port_a (
    .clk_sys (CLK),
    .rst_b   (RST),
    .rd_en   (RdEnA),
    .rd_addr (RdAddrA),
    .entries (mem),
    .wr_en   (WrEn),
    .wr_addr (WrAddr),
    .wr_data (WrData),
    .wr_strb (WrStrb),
    .rd_data (RdDataA),
    .rd_valid(RdValidA)
  );

  reg_file_rd_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .ZERO_REG(ZERO_REG)
  ) u_port_b (
    .clk_sys (CLK),
    .rst_b   (RST),
    .rd_en   (RdEnB),
    .rd_addr (RdAddrB),
    .entries (mem),
    .wr_en   (WrEn),
    .wr_addr (WrAddr),
    .wr_data (WrData),
    .wr_strb (WrStrb),
    .rd_data (RdDataB),
    .rd_valid(RdValidB)
  );

endmodule
